// File: rtl/calc_pkg.sv
// Shared calculator definitions: token field positions, operator codes,
// operator classification helpers and the infix converter's state encoding.
package calc_pkg;

  localparam int TOK_W    = 44;
  localparam int TYPE_HI  = 43;
  localparam int TYPE_LO  = 42;
  localparam int SIGN_BIT = 41;
  localparam int MANT_HI  = 40;
  localparam int MANT_LO  = 7;
  localparam int EXP_HI   = 6;
  localparam int EXP_LO   = 0;
  localparam int CODE_HI  = 7;

  localparam logic [1:0] TYPE_CONST = 2'b00;
  localparam logic [1:0] TYPE_OP    = 2'b01;

  localparam logic [7:0] OP_ADD   = 8'h2A;
  localparam logic [7:0] OP_SUB   = 8'h2B;
  localparam logic [7:0] OP_MUL   = 8'h2C;
  localparam logic [7:0] OP_DIV   = 8'h2D;
  localparam logic [7:0] OP_LPAR  = 8'h28;
  localparam logic [7:0] OP_RPAR  = 8'h29;
  localparam logic [7:0] OP_COMMA = 8'h2F;
  localparam logic [7:0] OP_EXP   = 8'hF0;
  localparam logic [7:0] OP_LN    = 8'hF1;
  localparam logic [7:0] OP_POW   = 8'hF2;
  localparam logic [7:0] OP_LOG   = 8'hF3;
  localparam logic [7:0] OP_SIN   = 8'hF4;
  localparam logic [7:0] OP_COS   = 8'hF5;
  localparam logic [7:0] OP_TAN   = 8'hF6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_POP_PREC,
    S_POP_PAREN,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic is_func(input logic [7:0] code);
    return (code == OP_EXP) || (code == OP_LN)  || (code == OP_POW) || (code == OP_LOG) ||
           (code == OP_SIN) || (code == OP_COS) || (code == OP_TAN);
  endfunction

  function automatic logic is_binop(input logic [7:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL) || (code == OP_DIV);
  endfunction

  function automatic logic [1:0] prec(input logic [7:0] code);
    if (code == OP_ADD || code == OP_SUB) return 2'd1;
    if (code == OP_MUL || code == OP_DIV) return 2'd2;
    if (is_func(code))                    return 2'd3;
    return 2'd0;
  endfunction

  // Operators live on the stack as bare codes; rebuild a full token on output.
  function automatic logic [TOK_W-1:0] op_token(input logic [7:0] code);
    return {TYPE_OP, {(TOK_W - 10){1'b0}}, code};
  endfunction

endpackage

// File: rtl/op_stack.sv
// LIFO of operator codes with top/below peek; pop+push in one cycle replaces the top.
// Synchronous active-low clear empties the stack without touching storage.
module op_stack #(
  parameter int DEPTH = 10,
  parameter int W     = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          clr_n,
  input  logic          push,
  input  logic          pop,
  input  logic          pop2,
  input  logic [W-1:0]  push_dat,
  output logic [W-1:0]  top,
  output logic [W-1:0]  below,
  output logic [CW-1:0] cnt,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;

  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    top   = '0;
    below = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) top   = mem_q[i];
      if (cnt_q == CW'(i + 2)) below = mem_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && ((pop && cnt_q == CW'(i + 1)) || (!pop && cnt_q == CW'(i))))
          mem_q[i] <= push_dat;
      end
      if (pop2 && cnt_q >= CW'(2))     cnt_q <= cnt_q - CW'(2);
      else if (push && !pop && !full)  cnt_q <= cnt_q + CW'(1);
      else if (pop && !push && !empty) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/infix_to_postfix.sv
// Shunting-yard converter from tokenised infix to postfix, one stack/output action per cycle.
// done pulses for one cycle at the end; error is held until the next accepted conv edge.
module infix_to_postfix
  import calc_pkg::*;
#(
  parameter int depth    = 10,
  parameter int newWidth = 44,
  localparam int IW      = $clog2(depth + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                conv,
  input  logic [IW-1:0]       infixSize,
  input  logic [newWidth-1:0] infix [depth],
  output logic [newWidth-1:0] postfix [depth],
  output logic [IW-1:0]       postfixSize,
  output logic                done,
  output logic                error
);

  state_t              state_q, state_d;
  logic [IW-1:0]       inp_q, out_idx_q, postfix_size_q;
  logic [newWidth-1:0] postfix_q [depth];
  logic                done_q, error_q, conv_prev_q;

  logic [newWidth-1:0] cur_tok, wr_dat;
  logic [7:0]          cur_code, push_dat, st_top, st_below;
  logic [IW-1:0]       st_cnt;
  logic                cur_is_const, conv_edge;
  logic                accept, inp_inc, wr_en, push, pop, pop2;
  logic                st_empty, st_full;

  assign postfix     = postfix_q;
  assign postfixSize = postfix_size_q;
  assign done        = done_q;
  assign error       = error_q;

  assign conv_edge = conv && !conv_prev_q;

  always_comb begin
    cur_tok = '0;
    for (int i = 0; i < depth; i++) begin
      if (inp_q == IW'(i)) cur_tok = infix[i];
    end
  end

  assign cur_code     = cur_tok[CODE_HI:0];
  assign cur_is_const = (cur_tok[TYPE_HI:TYPE_LO] == TYPE_CONST);

  op_stack #(.DEPTH(depth), .W(8)) u_stack (
    .clock    (clock),
    .clr_n    (reset && !accept),
    .push     (push),
    .pop      (pop),
    .pop2     (pop2),
    .push_dat (push_dat),
    .top      (st_top),
    .below    (st_below),
    .cnt      (st_cnt),
    .empty    (st_empty),
    .full     (st_full)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    inp_inc  = 1'b0;
    wr_en    = 1'b0;
    wr_dat   = cur_tok;
    push     = 1'b0;
    pop      = 1'b0;
    pop2     = 1'b0;
    push_dat = cur_code;
    case (state_q)
      S_IDLE: begin
        if (conv_edge) begin
          accept  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (inp_q >= infixSize) begin
          state_d = S_FLUSH;
        end else if (cur_is_const) begin
          wr_en   = 1'b1;
          inp_inc = 1'b1;
        end else if (is_func(cur_code) || cur_code == OP_LPAR) begin
          if (st_full) state_d = S_ERR;
          else begin
            push    = 1'b1;
            inp_inc = 1'b1;
          end
        end else if (is_binop(cur_code)) begin
          state_d = S_POP_PREC;
        end else if (cur_code == OP_RPAR || cur_code == OP_COMMA) begin
          state_d = S_POP_PAREN;
        end else begin
          state_d = S_ERR;
        end
      end
      S_POP_PREC: begin
        if (!st_empty && st_top != OP_LPAR && prec(st_top) >= prec(cur_code)) begin
          pop    = 1'b1;
          wr_en  = 1'b1;
          wr_dat = op_token(st_top);
        end else if (st_full) begin
          state_d = S_ERR;
        end else begin
          push    = 1'b1;
          inp_inc = 1'b1;
          state_d = S_READ;
        end
      end
      S_POP_PAREN: begin
        if (st_empty) begin
          state_d = S_ERR;
        end else if (st_top != OP_LPAR) begin
          pop    = 1'b1;
          wr_en  = 1'b1;
          wr_dat = op_token(st_top);
        end else begin
          inp_inc = 1'b1;
          state_d = S_READ;
          // Closing a function call emits the function together with dropping its '('.
          if (cur_code == OP_RPAR) begin
            if (st_cnt >= IW'(2) && is_func(st_below)) begin
              pop2   = 1'b1;
              wr_en  = 1'b1;
              wr_dat = op_token(st_below);
            end else begin
              pop = 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (st_empty) begin
          state_d = S_DONE;
        end else if (st_top == OP_LPAR) begin
          state_d = S_ERR;
        end else begin
          pop    = 1'b1;
          wr_en  = 1'b1;
          wr_dat = op_token(st_top);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      inp_q          <= '0;
      out_idx_q      <= '0;
      postfix_size_q <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      conv_prev_q    <= 1'b0;
      for (int i = 0; i < depth; i++) postfix_q[i] <= '0;
    end else begin
      conv_prev_q <= conv;
      done_q      <= 1'b0;
      state_q     <= state_d;
      if (accept) begin
        inp_q     <= '0;
        out_idx_q <= '0;
        error_q   <= 1'b0;
      end
      if (inp_inc) inp_q <= inp_q + IW'(1);
      if (wr_en) begin
        for (int i = 0; i < depth; i++) begin
          if (out_idx_q == IW'(i)) postfix_q[i] <= wr_dat;
        end
        out_idx_q <= out_idx_q + IW'(1);
      end
      if (state_q == S_DONE) begin
        postfix_size_q <= out_idx_q;
        done_q         <= 1'b1;
      end
      if (state_q == S_ERR) begin
        postfix_size_q <= '0;
        error_q        <= 1'b1;
        done_q         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_infix_to_postfix.sv
// Bench for infix_to_postfix: directed vector table, multi-cycle corner sequences,
// and random token streams scored against a queue-based shunting-yard model.
module tb_infix_to_postfix;

  localparam int D = 10;
  localparam int W = 44;

  localparam logic [15:0] ADD = 16'h2A, SUB = 16'h2B, MUL = 16'h2C, DIV = 16'h2D;
  localparam logic [15:0] LP  = 16'h28, RP  = 16'h29, CM  = 16'h2F;
  localparam logic [15:0] EXPF = 16'hF0, LNF = 16'hF1, POWF = 16'hF2, LOGF = 16'hF3, SINF = 16'hF4;

  logic          clock = 1'b0;
  logic          reset;
  logic          conv;
  logic [3:0]    infix_size;
  logic [3:0]    postfix_size;
  logic [W-1:0]  infix   [D];
  logic [W-1:0]  postfix [D];
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  infix_to_postfix #(.depth(D), .newWidth(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .conv        (conv),
    .infixSize   (infix_size),
    .infix       (infix),
    .postfix     (postfix),
    .postfixSize (postfix_size),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [0:9][15:0] in;
    int               n;
    logic [0:9][15:0] ex;
    int               ex_n;
    logic             ex_err;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [15:0] c(input int v);
    return 16'h100 | 16'(v);
  endfunction

  function automatic logic [0:9][15:0] L(input logic [15:0] a0 = 0, a1 = 0, a2 = 0, a3 = 0, a4 = 0,
                                          a5 = 0, a6 = 0, a7 = 0, a8 = 0, a9 = 0);
    return {a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
  endfunction

  function automatic vec_t mkv(input logic [0:9][15:0] in, input int n,
                               input logic [0:9][15:0] ex, input int ex_n, input logic ex_err);
    vec_t v;
    v.in = in; v.n = n; v.ex = ex; v.ex_n = ex_n; v.ex_err = ex_err;
    return v;
  endfunction

  function automatic logic [W-1:0] tok(input logic [15:0] x);
    if (x[8]) return {2'b00, 1'b0, 34'(x[7:0]), 7'h3F};
    return {2'b01, 34'd0, x[7:0]};
  endfunction

  // Operator type bits are not fixed by the interface, only "non-constant" plus the code.
  function automatic bit tok_ok(input logic [W-1:0] got, input logic [W-1:0] exp);
    if (exp[43:42] == 2'b00) return got == exp;
    return (got[43:42] != 2'b00) && (got[7:0] == exp[7:0]);
  endfunction

  function automatic int pr(input logic [7:0] cd);
    if (cd == 8'h2A || cd == 8'h2B) return 1;
    if (cd == 8'h2C || cd == 8'h2D) return 2;
    if (cd >= 8'hF0 && cd <= 8'hF6) return 3;
    return 0;
  endfunction

  function automatic bit is_fn(input logic [7:0] cd);
    return cd >= 8'hF0 && cd <= 8'hF6;
  endfunction

  function automatic logic [W-1:0] opt(input logic [7:0] cd);
    return {2'b01, 34'd0, cd};
  endfunction

  function automatic void model(input logic [W-1:0] t [D], input int n,
                                output logic [W-1:0] o [D], output int on, output bit err);
    logic [7:0] stk [$];
    logic [7:0] cd;
    int k = 0;
    err = 0;
    for (int i = 0; i < D; i++) o[i] = '0;
    for (int i = 0; i < n && !err; i++) begin
      cd = t[i][7:0];
      if (t[i][43:42] == 2'b00) begin
        o[k] = t[i]; k++;
      end else if (is_fn(cd) || cd == 8'h28) begin
        if (stk.size() == D) err = 1; else stk.push_back(cd);
      end else if (pr(cd) == 1 || pr(cd) == 2) begin
        while (stk.size() > 0 && stk[$] != 8'h28 && pr(stk[$]) >= pr(cd)) begin
          o[k] = opt(stk.pop_back()); k++;
        end
        if (stk.size() == D) err = 1; else stk.push_back(cd);
      end else if (cd == 8'h29 || cd == 8'h2F) begin
        while (stk.size() > 0 && stk[$] != 8'h28) begin
          o[k] = opt(stk.pop_back()); k++;
        end
        if (stk.size() == 0) err = 1;
        else if (cd == 8'h29) begin
          void'(stk.pop_back());
          if (stk.size() > 0 && is_fn(stk[$])) begin
            o[k] = opt(stk.pop_back()); k++;
          end
        end
      end else begin
        err = 1;
      end
    end
    while (!err && stk.size() > 0) begin
      if (stk[$] == 8'h28) err = 1;
      else begin
        o[k] = opt(stk.pop_back()); k++;
      end
    end
    on = err ? 0 : k;
  endfunction

  function automatic logic [W-1:0] rnd_tok();
    int r = $urandom_range(0, 99);
    logic [7:0] cd;
    if (r < 40) return {2'b00, 10'($urandom), 32'($urandom)};
    if (r < 65)      cd = 8'h2A + 8'($urandom_range(0, 3));
    else if (r < 75) cd = 8'h28;
    else if (r < 85) cd = 8'h29;
    else if (r < 93) cd = 8'hF0 + 8'($urandom_range(0, 6));
    else if (r < 97) cd = 8'h2F;
    else             cd = 8'($urandom);
    return {2'($urandom_range(1, 3)), 34'($urandom), cd};
  endfunction

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_and_check(input string nm, input logic [W-1:0] t [D], input int n,
                               input logic [W-1:0] ex [D], input int ex_n, input bit ex_err);
    bit seen;
    int bad;
    logic [63:0] ga, ge;
    for (int i = 0; i < D; i++) infix[i] = t[i];
    infix_size = 4'(n);
    conv = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge clock);
      conv = 1'b0;
      seen = done;
    end
    check(seen, {nm, "_done"}, 64'(seen), 64'd1);
    check(error == ex_err, {nm, "_error"}, 64'(error), 64'(ex_err));
    check(postfix_size == 4'(ex_n), {nm, "_size"}, 64'(postfix_size), 64'(ex_n));
    if (ex_n > 0) begin
      bad = -1;
      ga = '0;
      ge = '0;
      for (int i = 0; i < ex_n; i++) begin
        if (bad < 0 && !tok_ok(postfix[i], ex[i])) begin
          bad = i; ga = 64'(postfix[i]); ge = 64'(ex[i]);
        end
      end
      check(bad < 0, $sformatf("%s_token%0d", nm, bad), ga, ge);
    end
    @(negedge clock);
    check(done == 1'b0, {nm, "_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    logic [W-1:0] t [D];
    logic [W-1:0] ex [D];
    for (int i = 0; i < D; i++) begin
      t[i]  = tok(v.in[i]);
      ex[i] = tok(v.ex[i]);
    end
    run_and_check(nm, t, v.n, ex, v.ex_n, v.ex_err);
  endtask

  initial begin
    logic [W-1:0] t [D];
    logic [W-1:0] ex [D];
    int exn;
    bit exerr;
    int dcnt;
    logic [3:0] cap_sz;
    logic cap_err;

    vecs[0]  = mkv(L(c(1), ADD, c(2), MUL, c(3)), 5, L(c(1), c(2), c(3), MUL, ADD), 5, 0);
    vecs[1]  = mkv(L(LP, c(1), ADD, c(2), RP, MUL, c(3)), 7, L(c(1), c(2), ADD, c(3), MUL), 5, 0);
    vecs[2]  = mkv(L(SINF, LP, c(4), SUB, c(5), SUB, c(6), RP), 8, L(c(4), c(5), SUB, c(6), SUB, SINF), 6, 0);
    vecs[3]  = mkv(L(POWF, LP, c(2), CM, c(3), RP, ADD, c(1)), 8, L(c(2), c(3), POWF, c(1), ADD), 5, 0);
    vecs[4]  = mkv(L(LP, c(1), ADD, c(2)), 4, L(), 0, 1);
    vecs[5]  = mkv(L(c(1), ADD, c(2), RP), 4, L(), 0, 1);
    vecs[6]  = mkv(L(c(8), DIV, c(4), SUB, c(1)), 5, L(c(8), c(4), DIV, c(1), SUB), 5, 0);
    vecs[7]  = mkv(L(), 0, L(), 0, 0);
    vecs[8]  = mkv(L(c(1), 16'h33), 2, L(), 0, 1);
    vecs[9]  = mkv(L(LNF, LP, EXPF, LP, c(1), RP, RP), 7, L(c(1), EXPF, LNF), 3, 0);
    vecs[10] = mkv(L(LOGF, LP, c(1), CM, c(2), RP, MUL, LP, c(3), RP), 10, L(c(1), c(2), LOGF, c(3), MUL), 5, 0);
    vecs[11] = mkv(L(c(1), SUB, c(2), ADD, c(3)), 5, L(c(1), c(2), SUB, c(3), ADD), 5, 0);

    // Reset with conv already high: the first post-reset cycle must count as an edge.
    reset = 1'b0;
    conv  = 1'b1;
    for (int i = 0; i < D; i++) infix[i] = tok(vecs[0].in[i]);
    infix_size = 4'd5;
    repeat (3) @(negedge clock);
    check(done == 1'b0, "rst_done", 64'(done), 64'd0);
    check(error == 1'b0, "rst_error", 64'(error), 64'd0);
    check(postfix_size == 4'd0, "rst_size", 64'(postfix_size), 64'd0);
    check(postfix[0] == '0, "rst_postfix0", 64'(postfix[0]), 64'd0);
    reset = 1'b1;
    dcnt = 0;
    cap_sz = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clock);
      if (done) begin
        dcnt++;
        cap_sz = postfix_size;
      end
    end
    check(dcnt == 1, "held_conv_done_count", 64'(dcnt), 64'd1);
    check(cap_sz == 4'd5, "held_conv_size", 64'(cap_sz), 64'd5);
    conv = 1'b0;
    @(negedge clock);

    for (int k = 0; k < 12; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Reset in the middle of a conversion.
    for (int i = 0; i < D; i++) infix[i] = tok(vecs[2].in[i]);
    infix_size = 4'd8;
    conv = 1'b1;
    @(negedge clock);
    conv = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check(done == 1'b0, "midrst_done", 64'(done), 64'd0);
    check(error == 1'b0, "midrst_error", 64'(error), 64'd0);
    check(postfix_size == 4'd0, "midrst_size", 64'(postfix_size), 64'd0);
    check(postfix[0] == '0, "midrst_postfix0", 64'(postfix[0]), 64'd0);
    reset = 1'b1;
    dcnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    check(dcnt == 0, "midrst_idle", 64'(dcnt), 64'd0);
    run_vec("after_midrst", vecs[2]);

    // conv toggling while busy must not restart or add a second done.
    for (int i = 0; i < D; i++) infix[i] = tok(vecs[9].in[i]);
    infix_size = 4'd7;
    conv = 1'b1;
    dcnt = 0;
    cap_sz = '0;
    cap_err = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clock);
      if (done) begin
        dcnt++;
        cap_sz = postfix_size;
        cap_err = error;
      end
      conv = (cyc == 1 || cyc == 3);
    end
    check(dcnt == 1, "busy_done_count", 64'(dcnt), 64'd1);
    check(cap_sz == 4'd3, "busy_size", 64'(cap_sz), 64'd3);
    check(cap_err == 1'b0, "busy_error", 64'(cap_err), 64'd0);

    for (int r = 0; r < 300; r++) begin
      int n;
      n = $urandom_range(0, D);
      for (int i = 0; i < D; i++) t[i] = rnd_tok();
      model(t, n, ex, exn, exerr);
      run_and_check($sformatf("rnd%0d", r), t, n, ex, exn, exerr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
